// File: rtl/swap_restore_engine.sv
// Restores a swapped register pair with a three-step XOR exchange and hands the
// restored pair downstream over valid/ready, counting every delivered pair.
//
// state | meaning
// IDLE  | waiting for a pair, in_ready high
// X1    | a <= a ^ b
// X2    | b <= a ^ b
// X3    | a <= a ^ b, restored pair registered onto the outputs
// HOLD  | restored pair presented, waiting for out_ready
module swap_restore_engine #(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     reg1,
    input  logic [N-1:0]     reg2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     reg1_o,
    output logic [N-1:0]     reg2_o,
    output logic             busy,
    output logic [CNT_W-1:0] pair_cnt
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        X1   = 3'd1,
        X2   = 3'd2,
        X3   = 3'd3,
        HOLD = 3'd4
    } state_t;

    state_t         state;
    logic [N-1:0]   a;
    logic [N-1:0]   b;

    // HOLD frees up on the same edge the downstream takes the pair, allowing back-to-back loads.
    assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            a         <= '0;
            b         <= '0;
            reg1_o    <= '0;
            reg2_o    <= '0;
            out_valid <= 1'b0;
            pair_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a     <= reg1;
                        b     <= reg2;
                        state <= X1;
                    end
                end
                X1: begin
                    a     <= a ^ b;
                    state <= X2;
                end
                X2: begin
                    b     <= a ^ b;
                    state <= X3;
                end
                X3: begin
                    a         <= a ^ b;
                    reg1_o    <= a ^ b;
                    reg2_o    <= b;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        pair_cnt  <= pair_cnt + CNT_W'(1);
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            a     <= reg1;
                            b     <= reg2;
                            state <= X1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
